// File: rtl/eth_bridge_pkg.sv
// Shared Ethernet bridge definitions: MAC address constants, RX write-FSM encoding and
// the stored byte-word layout used by the receive frame buffer.
package eth_bridge_pkg;

  localparam int unsigned MAC_ADDR_W  = 48;
  localparam int unsigned MAC_BYTES   = MAC_ADDR_W / 8;
  localparam int unsigned BYTE_WORD_W = 9;

  localparam logic [MAC_ADDR_W-1:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;

  typedef enum logic [1:0] {
    WR_IDLE    = 2'd0,
    WR_RECV    = 2'd1,
    WR_DISCARD = 2'd2
  } wr_state_e;

  // One buffer entry: end-of-frame marker above the data byte.
  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } rx_word_t;

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered output that
// holds its value while rd_en is low.
module sdp_ram #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 9
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/rx_frame_buffer.sv
// Store-and-forward RX frame buffer between the MAC user interface and the bridge core.
// Optional destination-address filtering is enabled with `define RX_ADDR_FILTER_EN.
module rx_frame_buffer
  import eth_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W     = 11,
  parameter int unsigned DROP_CNT_W = 16
) (
  input  logic                  rx_mac_clk,
  input  logic                  reset,
  input  logic                  rx_mac_valid,
  input  logic [7:0]            rx_mac_data,
  input  logic                  rx_mac_last,
  input  logic                  rx_mac_err,
  output logic                  out_valid,
  output logic [7:0]            out_data,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic [ADDR_W-1:0]     frame_cnt,
  output logic [DROP_CNT_W-1:0] drop_cnt
`ifdef RX_ADDR_FILTER_EN
  ,
  input  logic [MAC_ADDR_W-1:0] local_mac
`endif
);

  localparam int unsigned PTR_W = ADDR_W + 1;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  wr_state_e              state_q, state_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       commit_ptr_q, commit_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic                   overflow_q, overflow_d;
  logic                   rd_pend_q, rd_pend_d;
  logic                   out_valid_q, out_valid_d;
  rx_word_t               out_word_q, out_word_d;
  logic [ADDR_W-1:0]      frame_cnt_q, frame_cnt_d;
  logic [DROP_CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

  logic [PTR_W-1:0] used_c;
  logic             full_c, addr_ok_c, commit_c, drop_c;
  logic             ram_we_c, ram_re_c, readable_c, accept_c, load_c, done_c;
  rx_word_t         ram_wword_c, ram_rdata;

  assign used_c = wr_ptr_q - rd_ptr_q;
  assign full_c = (used_c == PTR_W'(DEPTH));

`ifdef RX_ADDR_FILTER_EN
  logic [MAC_ADDR_W-1:0] dest_q, dest_d;
  logic [2:0]            hdr_cnt_q, hdr_cnt_d;
  logic [2:0]            hdr_idx_c;

  // Capture the first MAC_BYTES bytes of each frame as the destination address.
  always_comb begin
    dest_d    = dest_q;
    hdr_cnt_d = hdr_cnt_q;
    hdr_idx_c = (state_q == WR_IDLE) ? 3'd0 : hdr_cnt_q;
    if (rx_mac_valid && (hdr_idx_c < 3'(MAC_BYTES))) begin
      dest_d    = {dest_q[MAC_ADDR_W-9:0], rx_mac_data};
      hdr_cnt_d = hdr_idx_c + 3'd1;
    end
    addr_ok_c = (hdr_cnt_d == 3'(MAC_BYTES)) &&
                ((dest_d == local_mac) || (dest_d == BCAST_MAC));
  end

  always_ff @(posedge rx_mac_clk or negedge reset) begin
    if (!reset) begin
      dest_q    <= '0;
      hdr_cnt_q <= '0;
    end else begin
      dest_q    <= dest_d;
      hdr_cnt_q <= hdr_cnt_d;
    end
  end
`else
  assign addr_ok_c = 1'b1;
`endif

  // Write FSM: stream bytes in, commit or roll back on the last byte.
  always_comb begin
    state_d          = state_q;
    wr_ptr_d         = wr_ptr_q;
    commit_ptr_d     = commit_ptr_q;
    overflow_d       = overflow_q;
    ram_we_c         = 1'b0;
    commit_c         = 1'b0;
    drop_c           = 1'b0;
    ram_wword_c.last = rx_mac_last;
    ram_wword_c.data = rx_mac_data;
    if (rx_mac_valid) begin
      if (rx_mac_last) begin
        state_d = WR_IDLE;
        if (rx_mac_err || overflow_q || full_c || !addr_ok_c) begin
          wr_ptr_d   = commit_ptr_q;
          overflow_d = 1'b0;
          drop_c     = 1'b1;
        end else begin
          ram_we_c     = 1'b1;
          wr_ptr_d     = wr_ptr_q + PTR_W'(1);
          commit_ptr_d = wr_ptr_q + PTR_W'(1);
          commit_c     = 1'b1;
        end
      end else if (state_q != WR_DISCARD) begin
        if (full_c) begin
          overflow_d = 1'b1;
          state_d    = WR_DISCARD;
        end else begin
          ram_we_c = 1'b1;
          wr_ptr_d = wr_ptr_q + PTR_W'(1);
          state_d  = WR_RECV;
        end
      end
    end
  end

  // Read side: RAM read stage plus one output register, refilled on empty or accept.
  always_comb begin
    readable_c  = (rd_ptr_q != commit_ptr_q);
    accept_c    = out_valid_q && out_ready;
    load_c      = rd_pend_q && (!out_valid_q || out_ready);
    ram_re_c    = readable_c && (!rd_pend_q || load_c);
    rd_ptr_d    = ram_re_c ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    rd_pend_d   = ram_re_c || (rd_pend_q && !load_c);
    out_valid_d = out_valid_q;
    out_word_d  = out_word_q;
    if (load_c) begin
      out_valid_d = 1'b1;
      out_word_d  = ram_rdata;
    end else if (accept_c) begin
      out_valid_d = 1'b0;
    end
  end

  // Frame and drop counters; a commit and a final-byte accept in one cycle cancel.
  always_comb begin
    done_c      = accept_c && out_word_q.last;
    frame_cnt_d = frame_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    if (commit_c && !done_c) begin
      if (frame_cnt_q != '1) frame_cnt_d = frame_cnt_q + ADDR_W'(1);
    end else if (done_c && !commit_c) begin
      if (frame_cnt_q != '0) frame_cnt_d = frame_cnt_q - ADDR_W'(1);
    end
    if (drop_c && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
  end

  always_ff @(posedge rx_mac_clk or negedge reset) begin
    if (!reset) begin
      state_q      <= WR_IDLE;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      overflow_q   <= 1'b0;
      rd_pend_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_word_q   <= '0;
      frame_cnt_q  <= '0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      overflow_q   <= overflow_d;
      rd_pend_q    <= rd_pend_d;
      out_valid_q  <= out_valid_d;
      out_word_q   <= out_word_d;
      frame_cnt_q  <= frame_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  sdp_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (BYTE_WORD_W)
  ) u_ram (
    .clk     (rx_mac_clk),
    .wr_en   (ram_we_c),
    .wr_addr (wr_ptr_q[ADDR_W-1:0]),
    .wr_data (ram_wword_c),
    .rd_en   (ram_re_c),
    .rd_addr (rd_ptr_q[ADDR_W-1:0]),
    .rd_data (ram_rdata)
  );

  assign out_valid = out_valid_q;
  assign out_data  = out_word_q.data;
  assign out_last  = out_word_q.last;
  assign frame_cnt = frame_cnt_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_rx_frame_buffer.sv
// Directed bench for rx_frame_buffer (64-byte buffer instance) with an in-order byte
// scoreboard; filter frames are exercised when RX_ADDR_FILTER_EN is defined.
module tb_rx_frame_buffer;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned DCW    = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              rx_mac_valid = 1'b0;
  logic [7:0]        rx_mac_data = 8'h00;
  logic              rx_mac_last = 1'b0;
  logic              rx_mac_err = 1'b0;
  logic              out_valid, out_last;
  logic [7:0]        out_data;
  logic              out_ready = 1'b0;
  logic [ADDR_W-1:0] frame_cnt;
  logic [DCW-1:0]    drop_cnt;
`ifdef RX_ADDR_FILTER_EN
  logic [47:0]       local_mac = 48'h02_00_00_00_00_01;
`endif

  int          n_cmp = 0;
  int          n_err = 0;
  int          exp_drop = 0;
  int          acc_cnt = 0;
  int          fc_peak = 0;
  logic [8:0]  exp_q[$];
  logic        rand_rdy = 1'b0;
  logic        rdy_force = 1'b0;
  logic        prev_stall = 1'b0;
  logic [8:0]  prev_word = '0;

  rx_frame_buffer #(.ADDR_W(ADDR_W), .DROP_CNT_W(DCW)) dut (
    .rx_mac_clk   (clk),
    .reset        (rst_n),
    .rx_mac_valid (rx_mac_valid),
    .rx_mac_data  (rx_mac_data),
    .rx_mac_last  (rx_mac_last),
    .rx_mac_err   (rx_mac_err),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_last     (out_last),
    .out_ready    (out_ready),
    .frame_cnt    (frame_cnt),
    .drop_cnt     (drop_cnt)
`ifdef RX_ADDR_FILTER_EN
    ,
    .local_mac    (local_mac)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // out_ready changes just after the active edge, either forced or random.
  always begin
    @(posedge clk);
    #1;
    out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_force;
  end

  // Scoreboard collector and hold-while-stalled checker.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check_eq("hold_valid", 64'(out_valid), 64'd1);
        check_eq("hold_word", 64'({out_last, out_data}), 64'(prev_word));
      end
      if (out_valid && out_ready) begin
        acc_cnt++;
        check_eq("byte_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) check_eq("out_byte", 64'({out_last, out_data}), 64'(exp_q.pop_front()));
      end
      prev_stall = out_valid && !out_ready;
      prev_word  = {out_last, out_data};
      if (int'(frame_cnt) > fc_peak) fc_peak = int'(frame_cnt);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last, input logic err);
    rx_mac_valid = 1'b1;
    rx_mac_data  = d;
    rx_mac_last  = last;
    rx_mac_err   = err;
    cyc(1);
    rx_mac_valid = 1'b0;
    rx_mac_last  = 1'b0;
    rx_mac_err   = 1'b0;
  endtask

  // Frame of len bytes: optional 6-byte destination prefix, then base+i; keep queues it.
  task automatic send_frame(input int len, input logic [7:0] base, input logic err,
                            input bit keep, input bit use_dest = 1'b0,
                            input logic [47:0] dest = 48'h0);
    logic [7:0] b;
    for (int i = 0; i < len; i++) begin
      if (use_dest && i < 6) b = dest[47-8*i -: 8];
      else b = base + 8'(i);
      if (keep) exp_q.push_back({(i == len - 1), b});
      send_byte(b, (i == len - 1), err && (i == len - 1));
    end
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
    cyc(4);
    check_eq({tag, "_idle_valid"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    int acc0;
    int len;
    int space_wait;
    logic err;

    // Reset values
    #1;
    check_eq("rst_valid", 64'(out_valid), 64'd0);
    check_eq("rst_data", 64'(out_data), 64'd0);
    check_eq("rst_last", 64'(out_last), 64'd0);
    check_eq("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    check_eq("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    cyc(3);
    rst_n = 1'b1;
    rdy_force = 1'b1;
    cyc(3);

    // 64-byte good frame filling the buffer exactly, streamed with out_ready high
    fc_peak = 0;
    acc0 = acc_cnt;
    send_frame(64, 8'h10, 1'b0, 1'b1);
    @(negedge clk);
    check_eq("t1_frame_cnt_commit", 64'(frame_cnt), 64'd1);
    @(negedge clk);
    check_eq("t1_latency_not_yet", 64'(out_valid), 64'd0);
    @(negedge clk);
    check_eq("t1_latency_valid", 64'(out_valid), 64'd1);
    check_eq("t1_first_byte", 64'(out_data), 64'h10);
    cyc(1);
    wait_drain("t1", 400);
    check_eq("t1_count", 64'(acc_cnt - acc0), 64'd64);
    check_eq("t1_frame_cnt_end", 64'(frame_cnt), 64'd0);
    check_eq("t1_peak", 64'(fc_peak), 64'd1);
    check_eq("t1_drop_cnt", 64'(drop_cnt), 64'd0);

    // 60-byte frame with error on the last byte is rolled back
    send_frame(60, 8'h20, 1'b1, 1'b0);
    exp_drop++;
    cyc(8);
    check_eq("t2_no_output", 64'(out_valid), 64'd0);
    check_eq("t2_frame_cnt", 64'(frame_cnt), 64'd0);
    check_eq("t2_drop_cnt", 64'(drop_cnt), 64'(exp_drop));

    // Backpressured: 40-byte frame commits, second 40-byte frame overflows
    rdy_force = 1'b0;
    cyc(2);
    acc0 = acc_cnt;
    send_frame(40, 8'h40, 1'b0, 1'b1);
    send_frame(40, 8'h80, 1'b0, 1'b0);
    exp_drop++;
    cyc(4);
    check_eq("t3_drop_cnt", 64'(drop_cnt), 64'(exp_drop));
    check_eq("t3_frame_cnt", 64'(frame_cnt), 64'd1);
    check_eq("t3_stalled_valid", 64'(out_valid), 64'd1);
    check_eq("t3_stalled_data", 64'(out_data), 64'h40);
    rdy_force = 1'b1;
    wait_drain("t3", 400);
    check_eq("t3_count", 64'(acc_cnt - acc0), 64'd40);
    check_eq("t3_frame_cnt_end", 64'(frame_cnt), 64'd0);

    // Two back-to-back single-byte frames
    fc_peak = 0;
    acc0 = acc_cnt;
    send_frame(1, 8'hA5, 1'b0, 1'b1);
    send_frame(1, 8'h5A, 1'b0, 1'b1);
    wait_drain("t4", 50);
    check_eq("t4_count", 64'(acc_cnt - acc0), 64'd2);
    check_eq("t4_peak", 64'(fc_peak), 64'd2);
    check_eq("t4_frame_cnt_end", 64'(frame_cnt), 64'd0);

    // 200 frames with random out_ready, wrapping the pointers many times
    rand_rdy = 1'b1;
    for (int f = 0; f < 200; f++) begin
      len = int'($urandom_range(1, 24));
      err = (f % 7 == 3);
      space_wait = 0;
      while (exp_q.size() + len > DEPTH && space_wait < 2000) begin
        @(negedge clk);
        space_wait++;
      end
      if (space_wait >= 2000) check_eq("t5_space_timeout", 64'(exp_q.size()), 64'd0);
      cyc(1);
      if (err) exp_drop++;
      send_frame(len, 8'(f * 13), err, !err);
    end
    wait_drain("t5", 4000);
    rand_rdy = 1'b0;
    cyc(2);
    check_eq("t5_drop_cnt", 64'(drop_cnt), 64'(exp_drop));
    check_eq("t5_frame_cnt_end", 64'(frame_cnt), 64'd0);

`ifdef RX_ADDR_FILTER_EN
    // Destination filter: unicast and broadcast kept, other MAC and short frame dropped
    acc0 = acc_cnt;
    send_frame(10, 8'h60, 1'b0, 1'b1, 1'b1, 48'h02_00_00_00_00_01);
    send_frame(8, 8'h70, 1'b0, 1'b1, 1'b1, 48'hFF_FF_FF_FF_FF_FF);
    send_frame(10, 8'h90, 1'b0, 1'b0, 1'b1, 48'h02_00_00_00_00_02);
    send_frame(4, 8'h00, 1'b0, 1'b0, 1'b1, 48'h02_00_00_00_00_01);
    exp_drop += 2;
    wait_drain("t6", 200);
    check_eq("t6_count", 64'(acc_cnt - acc0), 64'd18);
    check_eq("t6_drop_cnt", 64'(drop_cnt), 64'(exp_drop));
`endif

    // Reset mid-frame with a committed frame stalled at the output
    rdy_force = 1'b0;
    cyc(2);
    send_frame(5, 8'h30, 1'b0, 1'b0);
    cyc(4);
    check_eq("t7_pre_valid", 64'(out_valid), 64'd1);
    check_eq("t7_pre_frame_cnt", 64'(frame_cnt), 64'd1);
    send_byte(8'hC1, 1'b0, 1'b0);
    send_byte(8'hC2, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_eq("t7_rst_valid", 64'(out_valid), 64'd0);
    check_eq("t7_rst_data", 64'(out_data), 64'd0);
    check_eq("t7_rst_last", 64'(out_last), 64'd0);
    check_eq("t7_rst_frame_cnt", 64'(frame_cnt), 64'd0);
    check_eq("t7_rst_drop_cnt", 64'(drop_cnt), 64'd0);
    cyc(2);
    @(negedge clk);
    rst_n = 1'b1;
    rdy_force = 1'b1;
    cyc(10);
    check_eq("t7_stale_gone", 64'(out_valid), 64'd0);
    acc0 = acc_cnt;
    send_frame(3, 8'hE0, 1'b0, 1'b1);
    wait_drain("t7", 50);
    check_eq("t7_count", 64'(acc_cnt - acc0), 64'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
